// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S word width and receiver FSM state encoding
package i2s_pkg;
  localparam int I2S_DATA_WIDTH = 16;
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} rx_state_e;
endpackage

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: I2S serial bus plus recovered parallel samples; frm_err exists only with I2S_RX_ERR_EN
interface i2s_rx_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH
);
  logic bclk;
  logic lrck;
  logic sdata;
  logic [DATA_WIDTH-1:0] l_data;
  logic [DATA_WIDTH-1:0] r_data;
  logic valid;
`ifdef I2S_RX_ERR_EN
  logic frm_err;
  modport master (output bclk, lrck, sdata, input l_data, r_data, valid, frm_err);
  modport slave (input bclk, lrck, sdata, output l_data, r_data, valid, frm_err);
`else
  modport master (output bclk, lrck, sdata, input l_data, r_data, valid);
  modport slave (input bclk, lrck, sdata, output l_data, r_data, valid);
`endif
endinterface

// File: rtl/i2s_rx_sync_edge.sv
// sync_edge: 2-FF synchronizer with a third stage giving registered, mutually aligned value and edge flags
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2;
  // q is the delayed synchronized value, so rise/fall refer to the same instant as q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      q <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      q <= s2;
      rise <= s2 & ~q;
      fall <= ~s2 & q;
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S receiver oversampled on clk; define I2S_RX_ERR_EN to add the frm_err channel-length check
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int CNT_W = $clog2(DATA_WIDTH + 1)
) (
  input logic clk,
  input logic rst_n,
  i2s_rx_if.slave bus
);
  localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
  logic bclk_rise, lrck_s, sdata_s;
  logic unused_bclk_q, unused_bclk_fall, unused_lrck_rise, unused_lrck_fall, unused_sdata_rise, unused_sdata_fall;
  rx_state_e state;
  logic lr_q, tr, valid;
  logic [CNT_W-1:0] cnt;
  logic [DATA_WIDTH-1:0] l_sh, r_sh, l_hold, l_data, r_data, mask, l_next, r_next;
  sync_edge u_bclk (.clk, .rst_n, .d(bus.bclk), .q(unused_bclk_q), .rise(bclk_rise), .fall(unused_bclk_fall));
  sync_edge u_lrck (.clk, .rst_n, .d(bus.lrck), .q(lrck_s), .rise(unused_lrck_rise), .fall(unused_lrck_fall));
  sync_edge u_sdata (.clk, .rst_n, .d(bus.sdata), .q(sdata_s), .rise(unused_sdata_rise), .fall(unused_sdata_fall));
  // lrck change since the previous bit edge marks the ending channel's LSB; mask selects the bit slot, empty once saturated
  always_comb begin
    tr = lrck_s != lr_q;
    mask = (cnt < CNT_W'(DATA_WIDTH)) ? MSB >> cnt : '0;
    l_next = sdata_s ? l_sh | mask : l_sh;
    r_next = sdata_s ? r_sh | mask : r_sh;
  end
`ifdef I2S_RX_ERR_EN
  logic frm_err, bad_len;
  assign bad_len = cnt != CNT_W'(DATA_WIDTH - 1);
  assign bus.frm_err = frm_err;
`endif
  // framing FSM: sync to a left start, assemble both channels MSB-first, publish the pair at the right LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      lr_q <= 1'b0;
      cnt <= '0;
      l_sh <= '0;
      r_sh <= '0;
      l_hold <= '0;
      l_data <= '0;
      r_data <= '0;
      valid <= 1'b0;
`ifdef I2S_RX_ERR_EN
      frm_err <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef I2S_RX_ERR_EN
      frm_err <= 1'b0;
`endif
      if (bclk_rise) begin
        lr_q <= lrck_s;
        cnt <= tr ? '0 : (cnt == CNT_W'(DATA_WIDTH)) ? cnt : cnt + 1'b1;
        case (state)
          SYNC: if (tr && !lrck_s) begin
            state <= LEFT;
            l_sh <= '0;
          end
          LEFT: if (tr) begin
            state <= RIGHT;
            l_hold <= l_next;
            r_sh <= '0;
`ifdef I2S_RX_ERR_EN
            frm_err <= bad_len;
`endif
          end else l_sh <= l_next;
          RIGHT: if (tr) begin
            state <= LEFT;
            l_data <= l_hold;
            r_data <= r_next;
            valid <= 1'b1;
            l_sh <= '0;
`ifdef I2S_RX_ERR_EN
            frm_err <= bad_len;
`endif
          end else r_sh <= r_next;
          default: state <= SYNC;
        endcase
      end
    end
  end
  assign bus.l_data = l_data;
  assign bus.r_data = r_data;
  assign bus.valid = valid;
endmodule
